// File: rtl/wall_pattern_if.sv
// Consumer-facing bundle of the wall pattern generator: refill read port,
// pattern controls and status flags.
interface wall_pattern_if;
  logic       hold;
  logic [5:0] data_addr;
  logic [1:0] difficulty;
  logic       pat_force_en;
  logic [4:0] pat_force;
  logic [5:0] data;
  logic       primed;
  logic       underrun;

  modport master (
    output hold, data_addr, difficulty, pat_force_en, pat_force,
    input  data, primed, underrun
  );

  modport slave (
    input  hold, data_addr, difficulty, pat_force_en, pat_force,
    output data, primed, underrun
  );
endinterface

// File: rtl/wall_pattern_gen.sv
// Double-banked procedural wall source: the front bank serves refill reads while an
// LFSR-driven emitter fills the back bank. Optional macro WALLGEN_MIRROR_EN adds mirroring.
module wall_pattern_gen #(
  parameter int unsigned WALL_THICK = 2,
  parameter int unsigned GAP_BASE   = 4,
  parameter int unsigned LEAD_IN    = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic           clk,
  input logic           reset,
  wall_pattern_if.slave bus
);

  localparam logic [4:0] LEAD_LAST  = 5'(LEAD_IN - 1);
  localparam logic [4:0] WALL_LAST  = 5'(WALL_THICK - 1);
  localparam logic [4:0] PGAP_LAST  = 5'(GAP_BASE - 1);
  localparam logic [4:0] GAP_BASE_W = 5'(GAP_BASE);

  typedef enum logic [2:0] {
    ST_LEAD = 3'd0,
    ST_PICK = 3'd1,
    ST_WALL = 3'd2,
    ST_GAP  = 3'd3,
    ST_PGAP = 3'd4
  } state_e;

  function automatic logic [5:0] rotl6(input logic [5:0] x, input logic [2:0] r);
    logic [11:0] dbl;
    dbl = {x, x} << r;
    return dbl[11:6];
  endfunction

  function automatic logic [5:0] pat_mask(input logic [1:0] sel, input logic [2:0] k);
    logic [5:0] m;
    case (sel)
      2'd0:    m = 6'b111110;
      2'd1:    m = k[0] ? 6'b010101 : 6'b101010;
      2'd2:    m = rotl6(6'b000111, k);
      2'd3:    m = k[0] ? 6'b110111 : 6'b111110;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] last_step(input logic [1:0] sel);
    logic [2:0] s;
    case (sel)
      2'd0:    s = 3'd0;
      2'd1:    s = 3'd2;
      2'd2:    s = 3'd5;
      2'd3:    s = 3'd3;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  // Rotation field is 3 bits but only six rotations exist; 6 and 7 fold onto 0 and 1.
  function automatic logic [2:0] fold_rot(input logic [2:0] r);
    return (r >= 3'd6) ? (r - 3'd6) : r;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  gap_len_q, gap_len_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  rot_q, rot_d;
  logic [5:0]  wp_q, wp_d;
  logic        back_full_q, back_full_d;
  logic        swap_pending_q, swap_pending_d;
  logic        primed_q, primed_d;
  logic        underrun_q, underrun_d;
  logic        front_q, front_d;
  logic        wr_en_d;
  logic [5:0]  wr_row_d;
  logic [5:0]  bank_q [2][64];

  logic [5:0]  mask_s;
  logic [4:0]  inter_gap_s;
  logic [4:0]  gap_now_s;
  logic        hit63_s;
  logic        swap_s;
  logic        back_sel_s;

`ifdef WALLGEN_MIRROR_EN
  logic mirror_q, mirror_d;

  function automatic logic [5:0] rev6(input logic [5:0] x);
    return {x[0], x[1], x[2], x[3], x[4], x[5]};
  endfunction

  // Mirror choice is latched once per pattern in PICK.
  always_comb begin
    mirror_d = mirror_q;
    if (!back_full_q && (state_q == ST_PICK)) begin
      mirror_d = lfsr_q[5] & ~bus.pat_force_en;
    end else begin
      mirror_d = mirror_q;
    end
  end

  // Mirror flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mirror_q <= 1'b0;
    end else begin
      mirror_q <= mirror_d;
    end
  end

  assign mask_s = mirror_q ? rev6(pat_mask(sel_q, k_q)) : pat_mask(sel_q, k_q);
`else
  assign mask_s = pat_mask(sel_q, k_q);
`endif

  assign back_sel_s   = ~front_q;
  assign bus.data     = primed_q ? bank_q[front_q][bus.data_addr] : 6'd0;
  assign bus.primed   = primed_q;
  assign bus.underrun = underrun_q;

  // Emission FSM: one row per active cycle, frozen while the back bank is full.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    sel_d       = sel_q;
    rot_d       = rot_q;
    gap_len_d   = gap_len_q;
    wr_en_d     = 1'b0;
    wr_row_d    = 6'd0;
    inter_gap_s = (GAP_BASE_W > {3'b000, bus.difficulty}) ?
                  (GAP_BASE_W - {3'b000, bus.difficulty}) : 5'd1;
    gap_now_s   = (cnt_q == 5'd0) ? inter_gap_s : gap_len_q;
    lfsr_d      = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
    if (!back_full_q) begin
      case (state_q)
        ST_LEAD: begin
          wr_en_d = 1'b1;
          if (cnt_q == LEAD_LAST) begin
            cnt_d   = 5'd0;
            state_d = ST_PICK;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ST_PICK: begin
          if (bus.pat_force_en) begin
            sel_d = bus.pat_force[1:0];
            rot_d = fold_rot(bus.pat_force[4:2]);
          end else begin
            sel_d = lfsr_q[1:0];
            rot_d = fold_rot(lfsr_q[4:2]);
          end
          k_d     = 3'd0;
          cnt_d   = 5'd0;
          state_d = ST_WALL;
        end
        ST_WALL: begin
          wr_en_d  = 1'b1;
          wr_row_d = rotl6(mask_s, rot_q);
          if (cnt_q == WALL_LAST) begin
            cnt_d   = 5'd0;
            state_d = (k_q == last_step(sel_q)) ? ST_PGAP : ST_GAP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ST_GAP: begin
          wr_en_d   = 1'b1;
          gap_len_d = gap_now_s;
          if ((cnt_q + 5'd1) == gap_now_s) begin
            cnt_d   = 5'd0;
            k_d     = k_q + 3'd1;
            state_d = ST_WALL;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ST_PGAP: begin
          wr_en_d = 1'b1;
          if (cnt_q == PGAP_LAST) begin
            cnt_d   = 5'd0;
            state_d = ST_PICK;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: begin
          cnt_d   = 5'd0;
          state_d = ST_LEAD;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Bank hand-over: a swap needs a full back bank; an early end-of-read is remembered.
  always_comb begin
    hit63_s        = bus.hold && (bus.data_addr == 6'd63);
    swap_s         = back_full_q && (!primed_q || swap_pending_q || hit63_s);
    front_d        = swap_s ? ~front_q : front_q;
    primed_d       = primed_q | swap_s;
    underrun_d     = underrun_q;
    swap_pending_d = swap_pending_q;
    wp_d           = wp_q;
    back_full_d    = back_full_q;
    if (swap_s) begin
      swap_pending_d = 1'b0;
      wp_d           = 6'd0;
      back_full_d    = 1'b0;
    end else if (primed_q && hit63_s && !back_full_q) begin
      underrun_d     = 1'b1;
      swap_pending_d = 1'b1;
      wp_d           = wr_en_d ? (wp_q + 6'd1) : wp_q;
      back_full_d    = wr_en_d && (wp_q == 6'd63);
    end else if (wr_en_d) begin
      wp_d        = wp_q + 6'd1;
      back_full_d = (wp_q == 6'd63);
    end else begin
      wp_d = wp_q;
    end
  end

  // State, control and bank storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_LEAD;
      lfsr_q         <= SEED;
      cnt_q          <= 5'd0;
      gap_len_q      <= 5'd0;
      k_q            <= 3'd0;
      sel_q          <= 2'd0;
      rot_q          <= 3'd0;
      wp_q           <= 6'd0;
      back_full_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      primed_q       <= 1'b0;
      underrun_q     <= 1'b0;
      front_q        <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        bank_q[0][i] <= 6'd0;
        bank_q[1][i] <= 6'd0;
      end
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      cnt_q          <= cnt_d;
      gap_len_q      <= gap_len_d;
      k_q            <= k_d;
      sel_q          <= sel_d;
      rot_q          <= rot_d;
      wp_q           <= wp_d;
      back_full_q    <= back_full_d;
      swap_pending_q <= swap_pending_d;
      primed_q       <= primed_d;
      underrun_q     <= underrun_d;
      front_q        <= front_d;
      if (wr_en_d) begin
        bank_q[back_sel_s][wp_q] <= wr_row_d;
      end
    end
  end

endmodule

// File: tb/tb_wall_pattern_gen.sv
// Scoreboarded bench for wall_pattern_gen: a queue-based row-stream model predicts every
// hold read (data, primed, underrun); a negedge monitor pops and compares.
module tb_wall_pattern_gen;
  localparam int WALL_THICK = 2;
  localparam int GAP_BASE   = 4;
  localparam int LEAD_IN    = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int NCYC = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  wall_pattern_if bus();

  wall_pattern_gen #(
    .WALL_THICK(WALL_THICK), .GAP_BASE(GAP_BASE), .LEAD_IN(LEAD_IN), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] data;
    logic       primed;
    logic       und;
    int         addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state
  logic [15:0] lfsr_at [NCYC];
  logic [5:0]  mfront [64];
  logic [5:0]  mback  [64];
  int          mq[$];
  int          back_end;
  int          mcyc;
  bit          mprimed, mund, mpend;
  bit          f_en;
  logic [4:0]  f_pf;
  int          f_diff;

  function automatic int rot6(input int x, input int r);
    return ((x << r) | (x >> (6 - r))) & 63;
  endfunction

  function automatic int rev6i(input int x);
    int y = 0;
    for (int i = 0; i < 6; i++) if ((x >> i) & 1) y |= (1 << (5 - i));
    return y;
  endfunction

  // Expand one chosen pattern into its full list of rows.
  function automatic void model_pick(input logic [15:0] l);
    int sel, r, rot, nst, gap, m;
    bit mir;
    if (f_en) begin
      sel = int'(f_pf[1:0]); r = int'(f_pf[4:2]); mir = 1'b0;
    end else begin
      sel = int'(l[1:0]); r = int'(l[4:2]); mir = l[5];
    end
    rot = (r >= 6) ? r - 6 : r;
    nst = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 6 : 4;
    gap = (GAP_BASE - f_diff >= 1) ? GAP_BASE - f_diff : 1;
    for (int k = 0; k < nst; k++) begin
      case (sel)
        0:       m = 62;
        1:       m = (k % 2 == 1) ? 21 : 42;
        2:       m = rot6(7, k);
        default: m = (k % 2 == 1) ? 55 : 62;
      endcase
`ifdef WALLGEN_MIRROR_EN
      if (mir) m = rev6i(m);
`endif
      m = rot6(m, rot);
      repeat (WALL_THICK) mq.push_back(m);
      repeat ((k == nst - 1) ? GAP_BASE : gap) mq.push_back(0);
    end
  endfunction

  // Produce a whole back bank starting at cycle `start`; an empty row queue costs a PICK cycle.
  task automatic model_fill(input int start);
    int c = start;
    int n = 0;
    while (n < 64) begin
      if (c >= NCYC) begin
        $display("FAIL model: cycle index %0d beyond table size %0d", c, NCYC);
        $fatal(1);
      end
      if (mq.size() == 0) model_pick(lfsr_at[c]);
      else begin
        mback[n] = 6'(mq.pop_front());
        n++;
      end
      c++;
    end
    back_end = c - 1;
  endtask

  // One clock cycle of stimulus; queue the expected read and apply bank hand-over rules.
  task automatic step(input logic h, input logic [5:0] a);
    exp_t e;
    bit   bf, hit;
    bus.hold      = h;
    bus.data_addr = a;
    if (h) begin
      e.data   = mprimed ? mfront[a] : 6'd0;
      e.primed = mprimed;
      e.und    = mund;
      e.addr   = int'(a);
      exp_q.push_back(e);
    end
    bf  = (back_end < mcyc);
    hit = h && (a == 6'd63);
    if (bf && (!mprimed || mpend || hit)) begin
      mfront  = mback;
      mprimed = 1'b1;
      mpend   = 1'b0;
      model_fill(mcyc + 1);
    end else if (mprimed && hit && !bf) begin
      mund  = 1'b1;
      mpend = 1'b1;
    end
    @(posedge clk);
    #1;
    mcyc++;
  endtask

  task automatic do_reset(input bit fen, input logic [4:0] pf, input logic [1:0] diff);
    reset             = 1'b1;
    bus.hold          = 1'b0;
    bus.data_addr     = 6'd0;
    bus.pat_force_en  = fen;
    bus.pat_force     = pf;
    bus.difficulty    = diff;
    f_en   = fen;
    f_pf   = pf;
    f_diff = int'(diff);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    repeat (LEAD_IN) mq.push_back(0);
    mprimed = 1'b0;
    mund    = 1'b0;
    mpend   = 1'b0;
    mcyc    = 0;
    for (int i = 0; i < 64; i++) mfront[i] = 6'd0;
    model_fill(0);
  endtask

  task automatic run(input bit fen, input logic [4:0] pf, input logic [1:0] diff,
                     input bit und_test, input int nsweep);
    int idle;
    do_reset(fen, pf, diff);
    for (int i = 0; i < 400 && !mprimed; i++) step(1'b1, 6'($urandom_range(62, 0)));
    if (und_test) begin
      step(1'b1, 6'd63);
      repeat (4) step(1'b1, 6'($urandom_range(62, 0)));
    end
    for (int s = 0; s < nsweep; s++) begin
      idle = $urandom_range(40, 0);
      for (int i = 0; i < idle; i++) step(1'($urandom_range(1, 0)), 6'($urandom_range(62, 0)));
      for (int a = 0; a < 64; a++) step(1'b1, 6'(a));
    end
    for (int i = 0; i < 80; i++) step(1'($urandom_range(1, 0)), 6'($urandom_range(62, 0)));
  endtask

  // Monitor: every hold read is a DUT response to be matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.hold) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL read_unexpected: addr %0d data=%b with empty scoreboard", bus.data_addr, bus.data);
      end else begin
        e = exp_q.pop_front();
        if (bus.data === e.data && bus.primed === e.primed && bus.underrun === e.und) n_pass++;
        else $display("FAIL read addr %0d @%0t: got data=%b primed=%b underrun=%b, expected data=%b primed=%b underrun=%b",
                      e.addr, $time, bus.data, bus.primed, bus.underrun, e.data, e.primed, e.und);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    lfsr_at[0] = SEED;
    for (int i = 1; i < NCYC; i++)
      lfsr_at[i] = lfsr_at[i-1][0] ? ((lfsr_at[i-1] >> 1) ^ 16'hB400) : (lfsr_at[i-1] >> 1);

    run(1'b1, 5'b000_00, 2'd0, 1'b0, 3);   // SINGLE, rot 0
    run(1'b1, 5'b000_10, 2'd3, 1'b0, 3);   // SPIRAL, max difficulty
    run(1'b1, 5'b010_00, 2'd0, 1'b0, 2);   // SINGLE, rot 2
    run(1'b1, 5'b111_00, 2'd0, 1'b0, 2);   // SINGLE, rot 7 folds to 1
    run(1'b1, 5'b000_01, 2'd0, 1'b0, 4);   // ALT across bank seams
    run(1'b0, 5'b000_00, 2'd1, 1'b1, 4);   // LFSR with early end-of-read
    run(1'b0, 5'b000_00, 2'd2, 1'b0, 4);
    for (int r = 0; r < 3; r++)
      run(1'b1, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 3);

    // Abort a fill part-way, then the identical configuration must replay identically.
    do_reset(1'b0, 5'b000_00, 2'd0);
    repeat ($urandom_range(60, 10)) step(1'($urandom_range(1, 0)), 6'($urandom_range(62, 0)));
    run(1'b0, 5'b000_00, 2'd0, 1'b0, 3);
    run(1'b0, 5'b000_00, 2'd0, 1'b1, 2);

    bus.hold = 1'b0;
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
